// File: rtl/keypad_pkg.sv
// Shared types, row drive constants and key decode for the keypad controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_PRESS,
    WAIT_RELEASE,
    DEBOUNCE_RELEASE
  } kp_state_e;

  // Active-low one-hot row drive patterns
  localparam logic [3:0] ROW0_N = 4'b1110;
  localparam logic [3:0] ROW1_N = 4'b1101;
  localparam logic [3:0] ROW2_N = 4'b1011;
  localparam logic [3:0] ROW3_N = 4'b0111;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    return ROW0_N;
      2'd1:    return ROW1_N;
      2'd2:    return ROW2_N;
      default: return ROW3_N;
    endcase
  endfunction

  // True when exactly one column is pulled low
  function automatic logic is_single(input logic [3:0] pat_n);
    case (pat_n)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Row index plus active-high column one-hot -> hex key code
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [3:0] col_oh);
    logic [1:0] c;
    case (col_oh)
      4'b0010: c = 2'd1;
      4'b0100: c = 2'd2;
      4'b1000: c = 2'd3;
      default: c = 2'd0;
    endcase
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pins plus decoded key/history outputs.
interface keypad_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_strobe;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       busy;

  modport master (
    input  col,
    output row, key_code, key_strobe, digit_new, digit_old, busy
  );

  modport slave (
    output col,
    input  row, key_code, key_strobe, digit_new, digit_old, busy
  );
endinterface

// File: rtl/keypad_controller_col_sync.sv
// Two-flop synchronizer for the asynchronous pulled-up column inputs.
module col_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;

  // Resets to all-high so an idle keypad is seen during and after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_controller.sv
// 4x4 keypad scan, press/release debounce and two-digit key history.
module keypad_controller
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD     = 6000,
  parameter int DEBOUNCE_CYCLES = 60000
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master kp
);
  localparam int SW = $clog2(SCAN_PERIOD);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_PERIOD - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_QUAL = SW'(2);

  kp_state_e     state, state_nxt;
  logic [SW-1:0] scan_cnt, scan_cnt_nxt;
  logic [DW-1:0] deb_cnt, deb_cnt_nxt;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [3:0]    lat_pat, lat_pat_nxt;
  logic [3:0]    csync;
  logic [3:0]    acc_code;
  logic          accept;

  col_sync u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (kp.col),
    .q     (csync)
  );

  // Row only moves in SCAN, so row_idx doubles as the latched row while debouncing
  assign kp.row   = row_drive(row_idx);
  assign acc_code = keymap(row_idx, ~lat_pat);

  // State, counters and latched pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SCAN;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      row_idx  <= 2'd0;
      lat_pat  <= 4'hF;
    end else begin
      state    <= state_nxt;
      scan_cnt <= scan_cnt_nxt;
      deb_cnt  <= deb_cnt_nxt;
      row_idx  <= row_idx_nxt;
      lat_pat  <= lat_pat_nxt;
    end
  end

  // Next-state: scan rows, debounce press, wait for release, debounce release
  always_comb begin
    state_nxt    = state;
    scan_cnt_nxt = scan_cnt;
    deb_cnt_nxt  = deb_cnt;
    row_idx_nxt  = row_idx;
    lat_pat_nxt  = lat_pat;
    accept       = 1'b0;
    case (state)
      SCAN: begin
        // First two counts of each row are blanked to hide synchronizer lag
        if (scan_cnt >= SCAN_QUAL && is_single(csync)) begin
          lat_pat_nxt = csync;
          deb_cnt_nxt = '0;
          state_nxt   = DEBOUNCE_PRESS;
        end else if (scan_cnt == SCAN_LAST) begin
          scan_cnt_nxt = '0;
          row_idx_nxt  = row_idx + 2'd1;
        end else begin
          scan_cnt_nxt = scan_cnt + 1'b1;
        end
      end
      DEBOUNCE_PRESS: begin
        if (csync != lat_pat) begin
          state_nxt    = SCAN;
          scan_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          accept    = 1'b1;
          state_nxt = WAIT_RELEASE;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (csync == 4'hF) begin
          deb_cnt_nxt = '0;
          state_nxt   = DEBOUNCE_RELEASE;
        end
      end
      DEBOUNCE_RELEASE: begin
        if (csync != 4'hF) begin
          state_nxt = WAIT_RELEASE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt    = SCAN;
          row_idx_nxt  = row_idx + 2'd1;
          scan_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  // Registered key outputs and history shift on each accepted press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp.key_code   <= 4'h0;
      kp.key_strobe <= 1'b0;
      kp.digit_new  <= 4'h0;
      kp.digit_old  <= 4'h0;
      kp.busy       <= 1'b0;
    end else begin
      kp.key_strobe <= accept;
      kp.busy       <= (state_nxt != SCAN);
      if (accept) begin
        kp.key_code  <= acc_code;
        kp.digit_new <= acc_code;
        kp.digit_old <= kp.digit_new;
      end
    end
  end
endmodule
